// File: rtl/axis_accum_pkg.sv
// Shared arithmetic helpers, lane state encoding and result record for the
// multi-channel AXI-Stream accumulator. Helpers work on a wide container and
// take the real width/signedness as arguments so every module can share them.
package axis_accum_pkg;

    localparam int ACC_MAX_W = 512;
    localparam int ID_MAX_W  = 8;
    localparam int CNT_MAX_W = 32;

    localparam logic LANE_IDLE_ENC   = 1'b0;
    localparam logic LANE_ACTIVE_ENC = 1'b1;

    typedef enum logic {
        LANE_IDLE   = LANE_IDLE_ENC,
        LANE_ACTIVE = LANE_ACTIVE_ENC
    } lane_state_e;

    typedef logic [ACC_MAX_W-1:0] wide_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0]  tid;
        wide_t                sum;
        logic [CNT_MAX_W-1:0] count;
        logic                 ovf;
    } accum_result_t;

    // All-ones mask covering the low w bits of the container.
    function automatic wide_t width_mask(input int w);
        wide_t one;
        one = wide_t'(1);
        if (w >= ACC_MAX_W) begin
            return '1;
        end
        return (one << w) - one;
    endfunction

    // Single bit of v at position idx.
    function automatic logic bit_at(input wide_t v, input int idx);
        return ((v >> idx) & wide_t'(1)) != '0;
    endfunction

    // Extends a dataw-bit addend to accw bits, zero- or sign-filling.
    function automatic wide_t accum_ext(input wide_t data, input int dataw,
                                        input int accw, input bit sgn);
        wide_t res;
        res = data & width_mask(dataw);
        if (sgn && bit_at(data, dataw - 1)) begin
            res = res | (width_mask(accw) & ~width_mask(dataw));
        end
        return res;
    endfunction

    // Overflow of an accw-bit add: carry out when unsigned, sign flip when signed.
    function automatic logic accum_ovf(input wide_t a, input wide_t b,
                                       input int accw, input bit sgn);
        wide_t              m;
        wide_t              sum;
        logic [ACC_MAX_W:0] full;
        m    = width_mask(accw);
        sum  = (a + b) & m;
        full = {1'b0, a & m} + {1'b0, b & m};
        if (sgn) begin
            return (bit_at(a, accw - 1) == bit_at(b, accw - 1)) &&
                   (bit_at(sum, accw - 1) != bit_at(a, accw - 1));
        end
        return ((full >> accw) & (ACC_MAX_W + 1)'(1)) != '0;
    endfunction

    // accw-bit sum, wrapping or clamping to the representable extreme.
    function automatic wide_t accum_sum(input wide_t a, input wide_t b,
                                        input int accw, input bit sgn,
                                        input bit sat);
        wide_t m;
        wide_t sum;
        m   = width_mask(accw);
        sum = (a + b) & m;
        if (sat && accum_ovf(a, b, accw, sgn)) begin
            if (!sgn) begin
                sum = m;
            end else if (bit_at(a, accw - 1)) begin
                sum = wide_t'(1) << (accw - 1);
            end else begin
                sum = m >> 1;
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/axis_multi_accumulator_lane.sv
// One channel of the accumulator: running sum, beat count and overflow flag,
// plus the packet result that the current beat would complete.
module accum_lane
    import axis_accum_pkg::*;
#(
    parameter int ACCW     = 72,
    parameter int CNTW     = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            beat_en,
    input  logic            last,
    input  logic [ACCW-1:0] addend,
    output logic [ACCW-1:0] res_sum,
    output logic [CNTW-1:0] res_count,
    output logic            res_ovf
);

    lane_state_e     state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic [ACCW-1:0] acc_base;
    logic [CNTW-1:0] cnt_base;
    logic            ovf_base;
    logic [ACCW-1:0] sum_next;
    logic [CNTW-1:0] cnt_next;
    logic            add_ovf;

    // Sum, count and overflow that result from adding the presented addend;
    // an idle lane starts from zero regardless of leftover register contents.
    always_comb begin
        acc_base = (state_q == LANE_ACTIVE) ? acc_q : '0;
        cnt_base = (state_q == LANE_ACTIVE) ? cnt_q : '0;
        ovf_base = (state_q == LANE_ACTIVE) ? ovf_q : 1'b0;
        sum_next = ACCW'(accum_sum(wide_t'(acc_base), wide_t'(addend), ACCW,
                                   SIGNED != 0, SATURATE != 0));
        add_ovf  = accum_ovf(wide_t'(acc_base), wide_t'(addend), ACCW, SIGNED != 0);
        cnt_next = (cnt_base == {CNTW{1'b1}}) ? cnt_base : cnt_base + CNTW'(1);
        res_sum   = sum_next;
        res_count = cnt_next;
        res_ovf   = ovf_base | add_ovf;
    end

    // Lane state update: accumulate on a middle beat, fall back to idle on the last.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (beat_en) begin
            if (last) begin
                state_d = LANE_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end else begin
                state_d = LANE_ACTIVE;
                acc_d   = sum_next;
                cnt_d   = cnt_next;
                ovf_d   = ovf_base | add_ovf;
            end
        end
    end

    // Lane registers, cleared by reset so partial packets are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LANE_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/axis_multi_accumulator.sv
// Multi-channel AXI-Stream accumulator: beats tagged by tid are summed per
// channel and each packet total is emitted on a result stream at tlast.
module axis_multi_accumulator
    import axis_accum_pkg::*;
#(
    parameter int DATAW      = 64,
    parameter int AXIS_DATAW = 512,
    parameter int ACCW       = 72,
    parameter int NUM_CH     = 4,
    parameter int IDW        = 2,
    parameter int CNTW       = 16,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [IDW-1:0]        s_tid,
    input  logic [AXIS_DATAW-1:0] s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [IDW-1:0]        m_tid,
    output logic [ACCW-1:0]       m_tdata,
    output logic [CNTW-1:0]       m_count,
    output logic                  m_ovf,
    output logic                  err_bad_id
);

    logic                  beat;
    logic                  id_ok;
    logic [ACCW-1:0]       addend;
    logic [NUM_CH-1:0]     lane_en;
    logic [ACCW-1:0]       lane_sum   [NUM_CH];
    logic [CNTW-1:0]       lane_count [NUM_CH];
    logic                  lane_ovf   [NUM_CH];

    logic [ACCW-1:0]       sel_sum;
    logic [CNTW-1:0]       sel_count;
    logic                  sel_ovf;

    logic                  m_tvalid_q, m_tvalid_d;
    logic [IDW-1:0]        m_tid_q, m_tid_d;
    logic [ACCW-1:0]       m_tdata_q, m_tdata_d;
    logic [CNTW-1:0]       m_count_q, m_count_d;
    logic                  m_ovf_q, m_ovf_d;
    logic                  err_bad_id_q, err_bad_id_d;

    // Only the low DATAW bits of the physical bus carry the addend.
    if (AXIS_DATAW > DATAW) begin : g_tdata_hi
        logic unused_tdata_hi;
        assign unused_tdata_hi = ^s_tdata[AXIS_DATAW-1:DATAW];
    end

    assign s_tready = !rst && (!m_tvalid_q || m_tready);
    assign beat     = s_tvalid && s_tready;
    assign id_ok    = (int'(s_tid) < NUM_CH);
    assign addend   = ACCW'(accum_ext(wide_t'(s_tdata[DATAW-1:0]), DATAW, ACCW,
                                      SIGNED != 0));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        assign lane_en[g] = beat && id_ok && (s_tid == IDW'(g));

        accum_lane #(
            .ACCW     (ACCW),
            .CNTW     (CNTW),
            .SIGNED   (SIGNED),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .beat_en   (lane_en[g]),
            .last      (s_tlast),
            .addend    (addend),
            .res_sum   (lane_sum[g]),
            .res_count (lane_count[g]),
            .res_ovf   (lane_ovf[g])
        );
    end

    // Pick the candidate result of the lane addressed by the incoming beat.
    always_comb begin
        sel_sum   = '0;
        sel_count = '0;
        sel_ovf   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s_tid == IDW'(i)) begin
                sel_sum   = lane_sum[i];
                sel_count = lane_count[i];
                sel_ovf   = lane_ovf[i];
            end
        end
    end

    // Output register: drains on handshake, reloads on a valid tlast beat in the
    // same cycle if one arrives, and latches the bad-id error.
    always_comb begin
        m_tvalid_d   = m_tvalid_q;
        m_tid_d      = m_tid_q;
        m_tdata_d    = m_tdata_q;
        m_count_d    = m_count_q;
        m_ovf_d      = m_ovf_q;
        err_bad_id_d = err_bad_id_q;
        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end
        if (beat && !id_ok) begin
            err_bad_id_d = 1'b1;
        end
        if (beat && id_ok && s_tlast) begin
            m_tvalid_d = 1'b1;
            m_tid_d    = s_tid;
            m_tdata_d  = sel_sum;
            m_count_d  = sel_count;
            m_ovf_d    = sel_ovf;
        end
    end

    // Result and error registers; reset drops any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid_q   <= 1'b0;
            m_tid_q      <= '0;
            m_tdata_q    <= '0;
            m_count_q    <= '0;
            m_ovf_q      <= 1'b0;
            err_bad_id_q <= 1'b0;
        end else begin
            m_tvalid_q   <= m_tvalid_d;
            m_tid_q      <= m_tid_d;
            m_tdata_q    <= m_tdata_d;
            m_count_q    <= m_count_d;
            m_ovf_q      <= m_ovf_d;
            err_bad_id_q <= err_bad_id_d;
        end
    end

    assign m_tvalid   = m_tvalid_q;
    assign m_tid      = m_tid_q;
    assign m_tdata    = m_tdata_q;
    assign m_count    = m_count_q;
    assign m_ovf      = m_ovf_q;
    assign err_bad_id = err_bad_id_q;

endmodule

// File: tb/tb_axis_multi_accumulator.sv
// Directed bench for axis_multi_accumulator: a default-parameter instance, three
// 8-bit instances (wrap, unsigned saturate, signed saturate) sharing one input
// stream, and a three-channel instance for out-of-range tid handling.
module tb_axis_multi_accumulator;
    import axis_accum_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic         a_s_tvalid, a_s_tready, a_s_tlast;
    logic [1:0]   a_s_tid;
    logic [511:0] a_s_tdata;
    logic         a_m_tvalid, a_m_tready, a_m_ovf, a_err;
    logic [1:0]   a_m_tid;
    logic [71:0]  a_m_tdata;
    logic [15:0]  a_m_count;

    logic         n_s_tvalid, n_s_tlast;
    logic [0:0]   n_s_tid;
    logic [7:0]   n_s_tdata;
    logic         n_m_tready;
    logic         b_s_tready, b_m_tvalid, b_m_ovf, b_err;
    logic [0:0]   b_m_tid;
    logic [7:0]   b_m_tdata;
    logic [15:0]  b_m_count;
    logic         c_s_tready, c_m_tvalid, c_m_ovf, c_err;
    logic [0:0]   c_m_tid;
    logic [7:0]   c_m_tdata;
    logic [15:0]  c_m_count;
    logic         d_s_tready, d_m_tvalid, d_m_ovf, d_err;
    logic [0:0]   d_m_tid;
    logic [7:0]   d_m_tdata;
    logic [15:0]  d_m_count;

    logic         e_s_tvalid, e_s_tready, e_s_tlast;
    logic [1:0]   e_s_tid;
    logic [15:0]  e_s_tdata;
    logic         e_m_tvalid, e_m_tready, e_m_ovf, e_err;
    logic [1:0]   e_m_tid;
    logic [15:0]  e_m_tdata;
    logic [15:0]  e_m_count;

    int testsRun    = 0;
    int testsFailed = 0;
    int aHandshakes = 0;

    axis_multi_accumulator u_dut_a (
        .clk(clk), .rst(rst),
        .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tlast(a_s_tlast),
        .s_tid(a_s_tid), .s_tdata(a_s_tdata),
        .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tid(a_m_tid),
        .m_tdata(a_m_tdata), .m_count(a_m_count), .m_ovf(a_m_ovf),
        .err_bad_id(a_err)
    );

    axis_multi_accumulator #(.DATAW(8), .AXIS_DATAW(8), .ACCW(8), .NUM_CH(1),
                             .IDW(1), .SIGNED(0), .SATURATE(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .s_tvalid(n_s_tvalid), .s_tready(b_s_tready), .s_tlast(n_s_tlast),
        .s_tid(n_s_tid), .s_tdata(n_s_tdata),
        .m_tvalid(b_m_tvalid), .m_tready(n_m_tready), .m_tid(b_m_tid),
        .m_tdata(b_m_tdata), .m_count(b_m_count), .m_ovf(b_m_ovf),
        .err_bad_id(b_err)
    );

    axis_multi_accumulator #(.DATAW(8), .AXIS_DATAW(8), .ACCW(8), .NUM_CH(1),
                             .IDW(1), .SIGNED(0), .SATURATE(1)) u_dut_c (
        .clk(clk), .rst(rst),
        .s_tvalid(n_s_tvalid), .s_tready(c_s_tready), .s_tlast(n_s_tlast),
        .s_tid(n_s_tid), .s_tdata(n_s_tdata),
        .m_tvalid(c_m_tvalid), .m_tready(n_m_tready), .m_tid(c_m_tid),
        .m_tdata(c_m_tdata), .m_count(c_m_count), .m_ovf(c_m_ovf),
        .err_bad_id(c_err)
    );

    axis_multi_accumulator #(.DATAW(8), .AXIS_DATAW(8), .ACCW(8), .NUM_CH(1),
                             .IDW(1), .SIGNED(1), .SATURATE(1)) u_dut_d (
        .clk(clk), .rst(rst),
        .s_tvalid(n_s_tvalid), .s_tready(d_s_tready), .s_tlast(n_s_tlast),
        .s_tid(n_s_tid), .s_tdata(n_s_tdata),
        .m_tvalid(d_m_tvalid), .m_tready(n_m_tready), .m_tid(d_m_tid),
        .m_tdata(d_m_tdata), .m_count(d_m_count), .m_ovf(d_m_ovf),
        .err_bad_id(d_err)
    );

    axis_multi_accumulator #(.DATAW(16), .AXIS_DATAW(16), .ACCW(16), .NUM_CH(3),
                             .IDW(2)) u_dut_e (
        .clk(clk), .rst(rst),
        .s_tvalid(e_s_tvalid), .s_tready(e_s_tready), .s_tlast(e_s_tlast),
        .s_tid(e_s_tid), .s_tdata(e_s_tdata),
        .m_tvalid(e_m_tvalid), .m_tready(e_m_tready), .m_tid(e_m_tid),
        .m_tdata(e_m_tdata), .m_count(e_m_count), .m_ovf(e_m_ovf),
        .err_bad_id(e_err)
    );

    // Count results actually delivered by the default instance.
    always @(posedge clk) begin
        if (!rst && a_m_tvalid && a_m_tready) begin
            aHandshakes <= aHandshakes + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one beat to the selected stream (0=default, 1=8-bit trio,
    // 2=three-channel) for exactly one clock edge.
    task automatic applyStimulus(input int target, input int tid,
                                 input logic [63:0] data, input bit last);
        case (target)
            0: begin
                a_s_tvalid = 1'b1; a_s_tid = 2'(tid);
                a_s_tdata = 512'(data); a_s_tlast = last;
            end
            1: begin
                n_s_tvalid = 1'b1; n_s_tdata = 8'(data); n_s_tlast = last;
            end
            default: begin
                e_s_tvalid = 1'b1; e_s_tid = 2'(tid);
                e_s_tdata = 16'(data); e_s_tlast = last;
            end
        endcase
        @(posedge clk);
        #1;
        a_s_tvalid = 1'b0;
        n_s_tvalid = 1'b0;
        e_s_tvalid = 1'b0;
    endtask

    function automatic accum_result_t mkResult(input int tid, input longint sum,
                                               input int count, input bit ovf);
        accum_result_t r;
        r.tid   = 8'(tid);
        r.sum   = wide_t'(sum);
        r.count = 32'(count);
        r.ovf   = ovf;
        return r;
    endfunction

    task automatic expectResult(input string tag, input accum_result_t exp);
        checkOutput({tag, "_valid"}, a_m_tvalid, 1);
        checkOutput({tag, "_tid"},   a_m_tid,    exp.tid);
        checkOutput({tag, "_tdata"}, a_m_tdata,  exp.sum[127:0]);
        checkOutput({tag, "_count"}, a_m_count,  exp.count);
        checkOutput({tag, "_ovf"},   a_m_ovf,    exp.ovf);
    endtask

    task automatic checkNarrow(input string tag, input int cnt,
                               input logic [7:0] eb, input bit ob,
                               input logic [7:0] ec, input bit oc,
                               input logic [7:0] ed, input bit od);
        checkOutput({tag, "_valid"},  b_m_tvalid & c_m_tvalid & d_m_tvalid, 1);
        checkOutput({tag, "_count"},  b_m_count, cnt);
        checkOutput({tag, "_wrap"},   b_m_tdata, eb);
        checkOutput({tag, "_wrapov"}, b_m_ovf,   ob);
        checkOutput({tag, "_usat"},   c_m_tdata, ec);
        checkOutput({tag, "_usatov"}, c_m_ovf,   oc);
        checkOutput({tag, "_ssat"},   d_m_tdata, ed);
        checkOutput({tag, "_ssatov"}, d_m_ovf,   od);
    endtask

    initial begin
        rst = 1'b1;
        a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_s_tid = '0; a_s_tdata = '0;
        a_m_tready = 1'b1;
        n_s_tvalid = 1'b0; n_s_tlast = 1'b0; n_s_tid = '0; n_s_tdata = '0;
        n_m_tready = 1'b1;
        e_s_tvalid = 1'b0; e_s_tlast = 1'b0; e_s_tid = '0; e_s_tdata = '0;
        e_m_tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tvalid", a_m_tvalid, 0);
        checkOutput("rst_tready", a_s_tready, 0);
        checkOutput("rst_tdata",  a_m_tdata,  0);
        checkOutput("rst_count",  a_m_count,  0);
        checkOutput("rst_err",    a_err,      0);
        checkOutput("rst_err_e",  e_err,      0);
        rst = 1'b0;

        // Three-beat packet on channel 0; result appears one cycle after tlast.
        applyStimulus(0, 0, 5, 0);
        applyStimulus(0, 0, 7, 0);
        checkOutput("t1_early", a_m_tvalid, 0);
        applyStimulus(0, 0, 9, 1);
        expectResult("t1", mkResult(0, 21, 3, 0));
        @(posedge clk); #1;
        checkOutput("t1_drain", a_m_tvalid, 0);

        // Interleaved channels 1 and 2, results back to back.
        applyStimulus(0, 1, 100, 0);
        applyStimulus(0, 2, 1, 0);
        applyStimulus(0, 1, 200, 1);
        expectResult("t2a", mkResult(1, 300, 2, 0));
        applyStimulus(0, 2, 2, 1);
        expectResult("t2b", mkResult(2, 3, 2, 0));
        @(posedge clk); #1;
        checkOutput("t2_drain", a_m_tvalid, 0);

        // Back-pressure: result held, input stalled, then released alongside a new tlast.
        a_m_tready = 1'b0;
        applyStimulus(0, 3, 10, 1);
        expectResult("t3_held", mkResult(3, 10, 1, 0));
        a_s_tvalid = 1'b1; a_s_tid = 2'd0; a_s_tdata = 512'd40; a_s_tlast = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_ready", a_s_tready, 0);
            checkOutput("hold_valid", a_m_tvalid, 1);
            checkOutput("hold_tid",   a_m_tid,    3);
            checkOutput("hold_tdata", a_m_tdata,  10);
        end
        a_m_tready = 1'b1;
        @(posedge clk); #1;
        a_s_tvalid = 1'b0;
        expectResult("t3_next", mkResult(0, 40, 1, 0));
        @(posedge clk); #1;
        checkOutput("t3_drain", a_m_tvalid, 0);

        // Reset mid-packet with a result pending.
        applyStimulus(0, 0, 50, 0);
        a_m_tready = 1'b0;
        applyStimulus(0, 1, 8, 1);
        checkOutput("t4_pending", a_m_tvalid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("t4_rst_valid", a_m_tvalid, 0);
        checkOutput("t4_rst_ready", a_s_tready, 0);
        checkOutput("t4_rst_err",   a_err,      0);
        checkOutput("t4_rst_tdata", a_m_tdata,  0);
        rst = 1'b0;
        a_m_tready = 1'b1;
        applyStimulus(0, 0, 4, 1);
        expectResult("t4", mkResult(0, 4, 1, 0));
        @(posedge clk); #1;
        checkOutput("a_results", aHandshakes, 6);

        // 8-bit instances: wrap / unsigned saturate / signed saturate.
        applyStimulus(1, 0, 200, 0);
        applyStimulus(1, 0, 100, 1);
        checkNarrow("n1", 2, 8'd44, 1, 8'd255, 1, 8'd44, 0);
        applyStimulus(1, 0, 100, 0);
        applyStimulus(1, 0, 100, 1);
        checkNarrow("n2", 2, 8'd200, 0, 8'd200, 0, 8'd127, 1);
        applyStimulus(1, 0, 250, 0);
        applyStimulus(1, 0, 10, 0);
        applyStimulus(1, 0, 1, 1);
        checkNarrow("n3", 3, 8'd5, 1, 8'd255, 1, 8'd5, 0);
        applyStimulus(1, 0, 156, 0);
        applyStimulus(1, 0, 156, 1);
        checkNarrow("n4", 2, 8'd56, 1, 8'd255, 1, 8'd128, 1);

        // Out-of-range tid on a three-channel instance.
        applyStimulus(2, 0, 10, 0);
        applyStimulus(2, 3, 99, 1);
        checkOutput("bad_err",   e_err,      1);
        checkOutput("bad_valid", e_m_tvalid, 0);
        applyStimulus(2, 1, 7, 1);
        checkOutput("bad_ch1_valid", e_m_tvalid, 1);
        checkOutput("bad_ch1_tid",   e_m_tid,    1);
        checkOutput("bad_ch1_tdata", e_m_tdata,  7);
        applyStimulus(2, 0, 5, 1);
        checkOutput("bad_ch0_tid",   e_m_tid,    0);
        checkOutput("bad_ch0_tdata", e_m_tdata,  15);
        checkOutput("bad_ch0_count", e_m_count,  2);
        checkOutput("bad_err_held",  e_err,      1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
